// File: rtl/pe_op_scheduler_if.sv
// Bundle of command, operand-memory, PE and output-buffer signals around pe_op_scheduler.
// slave = scheduler view; master = controller/memory/PE side.
interface pe_op_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_mode;
  logic [LEN_W-1:0]      cmd_len;
  logic [ADDR_W-1:0]     cmd_a_base;
  logic [ADDR_W-1:0]     cmd_b_base;
  logic [ADDR_W-1:0]     cmd_o_base;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_a_addr;
  logic [ADDR_W-1:0]     rd_b_addr;
  logic [DATA_WIDTH-1:0] rd_a_data;
  logic [DATA_WIDTH-1:0] rd_b_data;
  logic                  pe_valid_in;
  logic [1:0]            pe_mode;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [ACC_WIDTH-1:0]  pe_acc_in;
  logic                  pe_valid_out;
  logic [ACC_WIDTH-1:0]  pe_result;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ACC_WIDTH-1:0]  wr_data;
  logic                  done;
  logic                  err;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, cmd_a_base, cmd_b_base, cmd_o_base,
    input  rd_a_data, rd_b_data, pe_valid_out, pe_result,
    output cmd_ready, rd_en, rd_a_addr, rd_b_addr,
    output pe_valid_in, pe_mode, pe_a, pe_b, pe_acc_in,
    output wr_en, wr_addr, wr_data, done, err, busy
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_len, cmd_a_base, cmd_b_base, cmd_o_base,
    output rd_a_data, rd_b_data, pe_valid_out, pe_result,
    input  cmd_ready, rd_en, rd_a_addr, rd_b_addr,
    input  pe_valid_in, pe_mode, pe_a, pe_b, pe_acc_in,
    input  wr_en, wr_addr, wr_data, done, err, busy
  );
endinterface

// File: rtl/pe_op_scheduler.sv
// Descriptor-driven operand sequencer for one pipelined PE lane (MAC chaining, EWM/EWA streaming).
// Optional PE_SCHED_PERF_EN adds busy-cycle and completed-op counters.
module pe_op_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 10
) (
  input  logic clk,
  input  logic rst,
  pe_op_scheduler_if.slave bus
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [15:0] perf_ops
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_ILL = 2'b11;

  state_t            state;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] a_base, b_base, o_base;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_a_addr_r, rd_b_addr_r;
  logic              rd_en_r;
  logic              issue, issue_first;
  logic              drain_cnt;
  logic              done_r, err_r;
  logic              armed;
  logic              wr_fire;

  // armed gates PE results so nothing in flight across a reset can write
  assign wr_fire = armed && ((mode == MODE_MAC) ? done_r : bus.pe_valid_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode        <= '0;
      len         <= '0;
      idx         <= '0;
      a_base      <= '0;
      b_base      <= '0;
      o_base      <= '0;
      wr_idx      <= '0;
      rd_a_addr_r <= '0;
      rd_b_addr_r <= '0;
      rd_en_r     <= 1'b0;
      issue       <= 1'b0;
      issue_first <= 1'b0;
      drain_cnt   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      armed       <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      issue       <= rd_en_r;
      issue_first <= rd_en_r && (idx == LEN_W'(1));
      if (wr_fire && mode != MODE_MAC)
        wr_idx <= wr_idx + ADDR_W'(1);
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            mode   <= bus.cmd_mode;
            len    <= bus.cmd_len;
            a_base <= bus.cmd_a_base;
            b_base <= bus.cmd_b_base;
            o_base <= bus.cmd_o_base;
            idx    <= LEN_W'(1);
            wr_idx <= '0;
            if (bus.cmd_mode == MODE_ILL || bus.cmd_len == '0) begin
              state <= S_ERR;
              err_r <= 1'b1;
            end else begin
              state       <= S_RUN;
              rd_en_r     <= 1'b1;
              rd_a_addr_r <= bus.cmd_a_base;
              rd_b_addr_r <= bus.cmd_b_base;
              armed       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // idx is the index of the next element; equality means the last read is on the bus now
          if (idx == len) begin
            rd_en_r     <= 1'b0;
            rd_a_addr_r <= '0;
            rd_b_addr_r <= '0;
            drain_cnt   <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            rd_a_addr_r <= a_base + ADDR_W'(idx);
            rd_b_addr_r <= b_base + ADDR_W'(idx);
            idx         <= idx + LEN_W'(1);
          end
        end
        S_DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
            done_r    <= 1'b1;
          end else begin
            armed <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.rd_en       = rd_en_r;
  assign bus.rd_a_addr   = rd_a_addr_r;
  assign bus.rd_b_addr   = rd_b_addr_r;
  assign bus.pe_valid_in = issue;
  assign bus.pe_mode     = issue ? mode : 2'b00;
  assign bus.pe_a        = issue ? bus.rd_a_data : '0;
  assign bus.pe_b        = issue ? bus.rd_b_data : '0;
  // PE result is registered, so the previous element's sum is on pe_result exactly when the next issues
  assign bus.pe_acc_in   = (issue && !issue_first && mode == MODE_MAC) ? bus.pe_result : '0;
  assign bus.wr_en       = wr_fire;
  assign bus.wr_addr     = wr_fire ? (o_base + wr_idx) : '0;
  assign bus.wr_data     = wr_fire ? bus.pe_result : '0;

`ifdef PE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_ops         <= '0;
    end else begin
      if (state != S_IDLE)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (done_r)
        perf_ops <= perf_ops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_op_scheduler.sv
// Directed bench for pe_op_scheduler: behavioural operand memories and PE, cycle-stamped monitor.
module tb_pe_op_scheduler;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int ADW = 10;
  localparam int LW  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_op_scheduler_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_W(ADW), .LEN_W(LW)) bus ();

`ifdef PE_SCHED_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_ops;
`endif

  pe_op_scheduler #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_W(ADW), .LEN_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PE_SCHED_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_ops(perf_ops)
`endif
  );

  int tests_run = 0;
  int fails = 0;

  // operand memories, one-cycle registered read
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] rda = '0;
  logic [DW-1:0] rdb = '0;
  always @(posedge clk) begin
    if (bus.rd_en) begin
      rda <= mem_a[bus.rd_a_addr];
      rdb <= mem_b[bus.rd_b_addr];
    end
  end
  assign bus.rd_a_data = rda;
  assign bus.rd_b_data = rdb;

  // PE model: Q8.8 x Q8.8 -> Q16.16, one-cycle registered, result held while idle
  logic          pe_vo  = 1'b0;
  logic [AW-1:0] pe_res = '0;
  always @(posedge clk) begin
    logic signed [AW-1:0] p;
    logic signed [AW-1:0] s;
    p = $signed(bus.pe_a) * $signed(bus.pe_b);
    s = ($signed(bus.pe_a) + $signed(bus.pe_b)) <<< 8;
    pe_vo <= bus.pe_valid_in;
    if (bus.pe_valid_in) begin
      case (bus.pe_mode)
        2'b00:   pe_res <= bus.pe_acc_in + p;
        2'b01:   pe_res <= p;
        default: pe_res <= s;
      endcase
    end
  end
  assign bus.pe_valid_out = pe_vo;
  assign bus.pe_result    = pe_res;

  // monitor
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int acc_q[$];
  int wr_cyc_q[$];
  int wr_addr_q[$];
  logic [AW-1:0] wr_data_q[$];
  int done_q[$];
  int err_q[$];
  int ready_q[$];
  int iss_cyc_q[$];
  logic [AW-1:0] iss_acc_q[$];
  int rd_cnt = 0;
  logic ready_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready && !rst) acc_q.push_back(cyc);
    if (bus.wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(bus.wr_data);
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.err) err_q.push_back(cyc);
    if (bus.rd_en) rd_cnt = rd_cnt + 1;
    if (bus.pe_valid_in) begin
      iss_cyc_q.push_back(cyc);
      iss_acc_q.push_back(bus.pe_acc_in);
    end
    if (bus.cmd_ready && !ready_prev) ready_q.push_back(cyc);
    ready_prev = bus.cmd_ready;
  end

  task automatic clear_logs();
    acc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_q.delete(); err_q.delete(); ready_q.delete();
    iss_cyc_q.delete(); iss_acc_q.delete();
    rd_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_cmd(input logic [1:0] mode, input logic [LW-1:0] len,
                         input logic [ADW-1:0] a, input logic [ADW-1:0] b, input logic [ADW-1:0] o);
    bus.cmd_mode   = mode;
    bus.cmd_len    = len;
    bus.cmd_a_base = a;
    bus.cmd_b_base = b;
    bus.cmd_o_base = o;
    bus.cmd_valid  = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      fails++;
      $display("FAIL %s accept: cmd_ready never seen within 40 cycles, required 1", name);
    end
    step();
  endtask

  task automatic send(input logic [1:0] mode, input logic [LW-1:0] len,
                      input logic [ADW-1:0] a, input logic [ADW-1:0] b, input logic [ADW-1:0] o,
                      input string name);
    set_cmd(mode, len, a, b, o);
    wait_accept(name);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({bus.cmd_ready, bus.busy, bus.rd_en, bus.pe_valid_in, bus.wr_en, bus.done, bus.err} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_outputs: ready/busy/rd/pe/wr/done/err=%b required 1000000",
               {bus.cmd_ready, bus.busy, bus.rd_en, bus.pe_valid_in, bus.wr_en, bus.done, bus.err});
    end
    tests_run++;
    if (bus.pe_acc_in !== '0 || bus.wr_data !== '0) begin
      fails++;
      $display("FAIL reset_data: pe_acc_in=%h wr_data=%h required 0", bus.pe_acc_in, bus.wr_data);
    end
    step();
    rst = 1'b0;
    idle(2);
    tests_run++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: ready=%b busy=%b required 1/0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_mac();
    int t0;
    for (int i = 0; i < 4; i++) begin
      mem_a[i]       = 16'(16'h0100 * (i + 1));
      mem_b[100 + i] = 16'h0100;
    end
    clear_logs();
    send(2'b00, 10'd4, 10'd0, 10'd100, 10'd5, "mac");
    idle(12);
    t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    tests_run++;
    if (wr_cyc_q.size() != 1) begin
      fails++;
      $display("FAIL mac_wr_count: got %0d writes, required 1", wr_cyc_q.size());
    end else begin
      tests_run++;
      if (wr_cyc_q[0] != t0 + 6 || wr_addr_q[0] != 5 || wr_data_q[0] !== 32'h000A0000) begin
        fails++;
        $display("FAIL mac_write: cyc=T0+%0d addr=%0d data=%h required T0+6 5 000a0000",
                 wr_cyc_q[0] - t0, wr_addr_q[0], wr_data_q[0]);
      end
    end
    tests_run++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != t0 + 6)) begin
      fails++;
      $display("FAIL mac_done: count=%0d first=T0+%0d required one at T0+6",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1);
    end
    tests_run++;
    if (ready_q.size() < 1 || ready_q[0] != t0 + 7) begin
      fails++;
      $display("FAIL mac_ready: rise=T0+%0d required T0+7", (ready_q.size() > 0) ? ready_q[0] - t0 : -1);
    end
    tests_run++;
    if (rd_cnt != 4) begin
      fails++;
      $display("FAIL mac_reads: got %0d read cycles, required 4", rd_cnt);
    end
  endtask

  task automatic test_ewm_wrap();
    int t0;
    int exp_addr [3];
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000};
    for (int i = 0; i < 3; i++) begin
      mem_a[200 + i] = 16'hFF00;
      mem_b[300 + i] = 16'h0200;
    end
    clear_logs();
    send(2'b01, 10'd3, 10'd200, 10'd300, 10'h3FE, "ewm");
    idle(10);
    t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    tests_run++;
    if (wr_cyc_q.size() != 3) begin
      fails++;
      $display("FAIL ewm_wr_count: got %0d writes, required 3", wr_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (wr_cyc_q[i] != t0 + 3 + i || wr_addr_q[i] != exp_addr[i] || wr_data_q[i] !== 32'hFFFE0000) begin
          fails++;
          $display("FAIL ewm_write%0d: cyc=T0+%0d addr=%h data=%h required T0+%0d %h fffe0000",
                   i, wr_cyc_q[i] - t0, wr_addr_q[i], wr_data_q[i], 3 + i, exp_addr[i]);
        end
      end
    end
    tests_run++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != t0 + 5)) begin
      fails++;
      $display("FAIL ewm_done: count=%0d first=T0+%0d required one at T0+5",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1);
    end
  endtask

  task automatic test_ewa_single();
    int t0;
    mem_a[400] = 16'h0180;
    mem_b[500] = 16'h0080;
    clear_logs();
    send(2'b10, 10'd1, 10'd400, 10'd500, 10'd7, "ewa");
    idle(8);
    t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    tests_run++;
    if (wr_cyc_q.size() != 1) begin
      fails++;
      $display("FAIL ewa_wr_count: got %0d writes, required 1", wr_cyc_q.size());
    end else begin
      tests_run++;
      if (wr_cyc_q[0] != t0 + 3 || wr_addr_q[0] != 7 || wr_data_q[0] !== 32'h00020000) begin
        fails++;
        $display("FAIL ewa_write: cyc=T0+%0d addr=%0d data=%h required T0+3 7 00020000",
                 wr_cyc_q[0] - t0, wr_addr_q[0], wr_data_q[0]);
      end
    end
    tests_run++;
    if (iss_cyc_q.size() != 1 || (iss_acc_q.size() > 0 && iss_acc_q[0] !== '0)) begin
      fails++;
      $display("FAIL ewa_acc_in: issues=%0d acc=%h required 1 issue with acc 0",
               iss_cyc_q.size(), (iss_acc_q.size() > 0) ? iss_acc_q[0] : '1);
    end
  endtask

  task automatic test_illegal();
    int t0;
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      if (k == 0) send(2'b11, 10'd4, 10'd0, 10'd0, 10'd0, "ill_mode");
      else        send(2'b00, 10'd0, 10'd0, 10'd0, 10'd0, "ill_len");
      idle(6);
      t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
      tests_run++;
      if (err_q.size() != 1 || (err_q.size() > 0 && err_q[0] != t0 + 1)) begin
        fails++;
        $display("FAIL illegal%0d_err: count=%0d first=T0+%0d required one at T0+1",
                 k, err_q.size(), (err_q.size() > 0) ? err_q[0] - t0 : -1);
      end
      tests_run++;
      if (rd_cnt != 0 || done_q.size() != 0 || wr_cyc_q.size() != 0) begin
        fails++;
        $display("FAIL illegal%0d_side: reads=%0d dones=%0d writes=%0d required 0 0 0",
                 k, rd_cnt, done_q.size(), wr_cyc_q.size());
      end
      tests_run++;
      if (ready_q.size() < 1 || ready_q[0] != t0 + 2) begin
        fails++;
        $display("FAIL illegal%0d_ready: rise=T0+%0d required T0+2",
                 k, (ready_q.size() > 0) ? ready_q[0] - t0 : -1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    bit seen;
    mem_a[600] = 16'h0100; mem_a[601] = 16'h0200;
    mem_b[700] = 16'h0300; mem_b[701] = 16'h0100;
    mem_a[610] = 16'h0100; mem_a[611] = 16'h0100;
    mem_b[710] = 16'h0100; mem_b[711] = 16'h0100;
    clear_logs();
    set_cmd(2'b00, 10'd2, 10'd600, 10'd700, 10'd10);
    wait_accept("b2b_first");
    set_cmd(2'b00, 10'd2, 10'd610, 10'd710, 10'd11);
    wait_accept("b2b_second");
    bus.cmd_valid = 1'b0;
    idle(10);
    t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    t1 = (acc_q.size() > 1) ? acc_q[1] : -200;
    tests_run++;
    if (acc_q.size() != 2 || t1 - t0 != 5) begin
      fails++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d required 2 accepts 5 apart", acc_q.size(), t1 - t0);
    end
    tests_run++;
    if (wr_cyc_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_wr_count: got %0d writes, required 2", wr_cyc_q.size());
    end else begin
      tests_run++;
      if (wr_cyc_q[0] != t0 + 4 || wr_addr_q[0] != 10 || wr_data_q[0] !== 32'h00050000) begin
        fails++;
        $display("FAIL b2b_write0: cyc=T0+%0d addr=%0d data=%h required T0+4 10 00050000",
                 wr_cyc_q[0] - t0, wr_addr_q[0], wr_data_q[0]);
      end
      tests_run++;
      if (wr_cyc_q[1] != t1 + 4 || wr_addr_q[1] != 11 || wr_data_q[1] !== 32'h00020000) begin
        fails++;
        $display("FAIL b2b_write1: cyc=T1+%0d addr=%0d data=%h required T1+4 11 00020000",
                 wr_cyc_q[1] - t1, wr_addr_q[1], wr_data_q[1]);
      end
    end
    // chained accumulator on the first command, cleared on the second command's element 0
    for (int j = 0; j < 2; j++) begin
      int want_cyc;
      logic [AW-1:0] want_acc;
      want_cyc = (j == 0) ? t0 + 3 : t1 + 2;
      want_acc = (j == 0) ? 32'h00030000 : 32'h0;
      seen = 1'b0;
      tests_run++;
      for (int i = 0; i < iss_cyc_q.size(); i++) begin
        if (iss_cyc_q[i] == want_cyc) begin
          seen = 1'b1;
          if (iss_acc_q[i] !== want_acc) begin
            fails++;
            $display("FAIL b2b_acc_in%0d: pe_acc_in=%h required %h", j, iss_acc_q[i], want_acc);
          end
        end
      end
      if (!seen) begin
        fails++;
        $display("FAIL b2b_issue%0d: no pe_valid_in at expected cycle, required one", j);
      end
    end
  endtask

  task automatic test_reset_midop();
    int t0;
    for (int i = 0; i < 8; i++) begin
      mem_a[800 + i] = 16'h0100;
      mem_b[900 + i] = 16'h0100;
    end
    clear_logs();
    send(2'b01, 10'd8, 10'd800, 10'd900, 10'd20, "rst_mid");
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.cmd_ready, bus.busy, bus.rd_en, bus.pe_valid_in, bus.wr_en, bus.done} !== 6'b100000) begin
      fails++;
      $display("FAIL midrst_outputs: ready/busy/rd/pe/wr/done=%b required 100000",
               {bus.cmd_ready, bus.busy, bus.rd_en, bus.pe_valid_in, bus.wr_en, bus.done});
    end
    tests_run++;
    if (bus.pe_a !== '0 || bus.pe_acc_in !== '0 || bus.rd_a_addr !== '0) begin
      fails++;
      $display("FAIL midrst_data: pe_a=%h acc=%h rd_a_addr=%h required 0",
               bus.pe_a, bus.pe_acc_in, bus.rd_a_addr);
    end
    step();
    rst = 1'b0;
    idle(12);
    tests_run++;
    if (wr_cyc_q.size() != 0 || done_q.size() != 0 || bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_quiet: writes=%0d dones=%0d ready=%b required 0 0 1",
               wr_cyc_q.size(), done_q.size(), bus.cmd_ready);
    end
    clear_logs();
    send(2'b10, 10'd1, 10'd400, 10'd500, 10'd9, "post_rst");
    idle(8);
    t0 = (acc_q.size() > 0) ? acc_q[0] : -100;
    tests_run++;
    if (wr_cyc_q.size() != 1 || (wr_cyc_q.size() > 0 &&
        (wr_cyc_q[0] != t0 + 3 || wr_addr_q[0] != 9 || wr_data_q[0] !== 32'h00020000))) begin
      fails++;
      $display("FAIL postrst_write: writes=%0d required one 00020000 at addr 9, T0+3", wr_cyc_q.size());
    end
    tests_run++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != t0 + 3)) begin
      fails++;
      $display("FAIL postrst_done: count=%0d required one at T0+3", done_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'b00;
    bus.cmd_len    = '0;
    bus.cmd_a_base = '0;
    bus.cmd_b_base = '0;
    bus.cmd_o_base = '0;
    test_reset();
    test_mac();
    test_ewm_wrap();
    test_ewa_single();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/pe_op_scheduler.md
Name: pe_op_scheduler

Overview:
Command-driven sequencer for one pipelined PE lane (MAC/EWM/EWA, 1-cycle registered result).
- Accepts an operation descriptor and streams operands from two single-port operand memories into the PE.
- Chains MAC partial sums by feeding the PE result back to its accumulator input.
- Writes results to an output buffer, then pulses done.
- Sits between the layer-level controller and a PE lane.

Parameters:
DATA_WIDTH, 16, operand width (Q8.8)
ACC_WIDTH, 32, PE result width (Q16.16)
ADDR_W, 10, operand/output memory address width
LEN_W, 10, element-count width (max len 2^LEN_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  high only in IDLE
cmd_mode  in  2  00 MAC, 01 EWM, 10 EWA, 11 illegal
cmd_len  in  LEN_W  element count
cmd_a_base / cmd_b_base / cmd_o_base  in  ADDR_W each  base addresses
rd_en  out  1  operand read strobe; data returns 1 cycle later
rd_a_addr / rd_b_addr  out  ADDR_W  read addresses
rd_a_data / rd_b_data  in  DATA_WIDTH  read data
pe_valid_in  out  1  PE issue strobe
pe_mode  out  2  mode to PE
pe_a / pe_b  out  DATA_WIDTH  operands to PE (combinational from rd_*_data)
pe_acc_in  out  ACC_WIDTH  accumulator input to PE
pe_valid_out  in  1  PE result valid
pe_result  in  ACC_WIDTH  PE result (held while PE idle)
wr_en  out  1  output write strobe, no backpressure
wr_addr  out  ADDR_W  output address
wr_data  out  ACC_WIDTH  = pe_result
done  out  1  1-cycle completion pulse
err  out  1  1-cycle illegal-command pulse
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM: IDLE -> RUN -> DRAIN -> IDLE.
- Reset (any time, including mid-op):
  - state IDLE; index and drain counters 0.
  - All outputs 0 except cmd_ready=1.
  - In-flight elements discarded; pe_valid_out is ignored until the next accepted command.
- Accept occurs on cmd_valid && cmd_ready (cycle T0). Mode, len and bases are latched.
- Illegal command (mode 11 or len 0): no reads issued; err=1 and busy=1 in T0+1; cmd_ready=1 again in T0+2; done never asserted.
- RUN, cycles T0+1 .. T0+L:
  - rd_en=1.
  - Element i: rd_a_addr = a_base+i, rd_b_addr = b_base+i, modulo 2^ADDR_W (wrap, no error).
- Issue stage, one cycle after each read:
  - pe_valid_in=1; pe_mode = latched mode.
  - pe_acc_in = 0 for element 0 and in EWM/EWA; otherwise pe_acc_in = pe_result (the prior element's sum, available back-to-back).
  - pe_valid_in, pe_a, pe_b and pe_acc_in are 0 when not issuing.
- DRAIN: 2 cycles after the last read; RUN->DRAIN on the cycle i=L-1 is issued.
- Writes:
  - EWM/EWA: wr_en = pe_valid_out, element i at cycle T0+i+3, wr_addr = o_base+i (wrapping).
  - MAC: single write at T0+L+2, wr_addr = o_base, wr_data = final sum; intermediate pe_valid_out does not write.
- done=1 at T0+L+2, coincident with the last wr_en. cmd_ready returns at T0+L+3.
- Minimum accept-to-accept spacing is L+3 cycles; the next command may be accepted in that cycle.
- cmd_valid while busy is ignored. Descriptor inputs are sampled only at accept.
- No overflow handling: sums wrap at ACC_WIDTH (two's complement) inside the PE.

Optional Feature:
PE_SCHED_PERF_EN
- Defined:
  - adds outputs perf_busy_cycles[31:0] (increments each cycle busy=1) and perf_ops[15:0] (increments on each done).
  - Both wrap; both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. MAC, L=4, a=0x0100,0x0200,0x0300,0x0400, b=0x0100 x4, o_base=5 -> exactly one wr_en, at T0+6, wr_addr=5, wr_data=0x000A0000; done at T0+6; cmd_ready at T0+7.
2. EWM, L=3, a=0xFF00 x3, b=0x0200 x3, o_base=0x3FE -> writes at T0+3..T0+5 to 0x3FE, 0x3FF, 0x000, each 0xFFFE0000.
3. EWA, L=1, a=0x0180, b=0x0080 -> single write 0x00020000 at T0+3; pe_acc_in=0 throughout.
4. Illegal: mode=11, L=4 -> err at T0+1, rd_en never high, no done, cmd_ready at T0+2; then len=0 with mode 00 -> same.
5. Back-to-back: cmd_valid held high with two MAC L=2 commands -> second accepted exactly at T0+5; the second command's element 0 gets pe_acc_in=0 (no carry-over).
6. rst asserted at T0+2 of an L=8 EWM -> outputs cleared immediately, no wr_en afterwards, cmd_ready=1; a new L=1 command then completes normally.
